// File: rtl/sipo_deser.sv
// LSB-first serial-in parallel-out deserializer with a valid/ready holding
// register and a sticky overrun flag for words dropped while output is full.
module sipo_deser #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
  input  logic             shift_en,
  input  logic             sync,
  input  logic             out_ready,
  input  logic             clr_ovr,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_shreg;
  logic [CW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_data_out;
  logic             r_out_valid;
  logic             r_overrun;

  logic [WIDTH-1:0] w_word;
  logic             w_last;
  logic             w_done;
  logic             w_accept;
  logic             w_drop;
  logic             w_consume;

  // A sync on a shift cycle restarts the count at 1, so it can never complete a frame.
  assign w_word    = {data_in, r_shreg[WIDTH-1:1]};
  assign w_last    = (r_bit_cnt == CW'(WIDTH - 1));
  assign w_done    = shift_en && !sync && w_last;
  assign w_consume = r_out_valid && out_ready;
  assign w_accept  = w_done && (!r_out_valid || out_ready);
  assign w_drop    = w_done && r_out_valid && !out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
    end else if (shift_en) begin
      r_shreg <= w_word;
      if (sync)
        r_bit_cnt <= CW'(1);
      else if (w_last)
        r_bit_cnt <= '0;
      else
        r_bit_cnt <= r_bit_cnt + 1'b1;
    end else if (sync) begin
      r_bit_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_data_out  <= w_word;
      r_out_valid <= 1'b1;
    end else if (w_consume) begin
      r_out_valid <= 1'b0;
    end
  end

  // A drop on the same edge as a clear leaves the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_overrun <= 1'b0;
    else if (w_drop)
      r_overrun <= 1'b1;
    else if (clr_ovr)
      r_overrun <= 1'b0;
  end

  assign data_out  = r_data_out;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;
  assign busy      = (r_bit_cnt != '0);

endmodule

// File: tb/tb_sipo_deser.sv
// Scoreboard bench for sipo_deser: expected words are queued when driven and
// compared whenever the DUT hands a word over through valid/ready.
module tb_sipo_deser;

  logic       clk;
  logic       rst;
  logic       data_in;
  logic       shift_en;
  logic       sync;
  logic       out_ready;
  logic       clr_ovr;
  logic [7:0] data_out;
  logic       out_valid;
  logic       overrun;
  logic       busy;

  logic       tb_bit;
  logic       link_mode;
  logic       tx_load;
  logic [7:0] tx_din;
  logic [7:0] tx_sh;
  logic       tx_out;

  int total;
  int bad;
  logic [7:0] sb[$];

  sipo_deser #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .shift_en  (shift_en),
    .sync      (sync),
    .out_ready (out_ready),
    .clr_ovr   (clr_ovr),
    .data_out  (data_out),
    .out_valid (out_valid),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural PISO transmitter: drives 0 in its load cycle, then LSB-first.
  assign tx_out  = tx_load ? 1'b0 : tx_sh[0];
  assign data_in = link_mode ? tx_out : tb_bit;

  always @(posedge clk) begin
    if (tx_load)
      tx_sh <= tx_din;
    else
      tx_sh <= {1'b0, tx_sh[7:1]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0)
        check("sb_unexpected_word", {24'h0, data_out}, 32'hFFFF_FFFF);
      else
        check("sb_word", {24'h0, data_out}, {24'h0, sb.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic s);
    tb_bit   = b;
    shift_en = 1'b1;
    sync     = s;
    tick();
    shift_en = 1'b0;
    sync     = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_bit(w[i], 1'b0);
  endtask

  task automatic link_send(input logic [7:0] w);
    link_mode = 1'b1;
    tx_din    = w;
    tx_load   = 1'b1;
    shift_en  = 1'b0;
    tick();
    tx_load   = 1'b0;
    shift_en  = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    shift_en  = 1'b0;
    link_mode = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] pair;
    total = 0;
    bad = 0;
    rst = 1'b0;
    tb_bit = 1'b0;
    shift_en = 1'b0;
    sync = 1'b0;
    out_ready = 1'b0;
    clr_ovr = 1'b0;
    link_mode = 1'b0;
    tx_load = 1'b0;
    tx_din = 8'h00;
    repeat (3) tick();
    check("rst_data", {24'h0, data_out}, 32'h0);
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_ovr", {31'h0, overrun}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    rst = 1'b1;
    tick();

    // 0xA5 held unconsumed
    for (int i = 0; i < 8; i++) begin
      send_bit(1'(8'hA5 >> i), 1'b0);
      if (i == 2) check("a5_busy_mid", {31'h0, busy}, 32'h1);
    end
    check("a5_data", {24'h0, data_out}, 32'hA5);
    check("a5_valid", {31'h0, out_valid}, 32'h1);
    check("a5_busy", {31'h0, busy}, 32'h0);
    check("a5_ovr", {31'h0, overrun}, 32'h0);
    sb.push_back(8'hA5);
    out_ready = 1'b1;
    tick();
    check("a5_consumed", {31'h0, out_valid}, 32'h0);

    // back-to-back 0x3C, 0xC3 with out_ready high
    pair = 16'hC33C;
    sb.push_back(8'h3C);
    sb.push_back(8'hC3);
    for (int i = 0; i < 16; i++) begin
      send_bit(pair[i], 1'b0);
      check("b2b_valid", {31'h0, out_valid}, (i == 7 || i == 15) ? 32'h1 : 32'h0);
      if (i == 7)  check("b2b_data0", {24'h0, data_out}, 32'h3C);
      if (i == 15) check("b2b_data1", {24'h0, data_out}, 32'hC3);
    end
    tick();
    check("b2b_ovr", {31'h0, overrun}, 32'h0);

    // overrun: 0x11 held, 0x22 dropped
    out_ready = 1'b0;
    send_word(8'h11);
    send_word(8'h22);
    check("ovr_data", {24'h0, data_out}, 32'h11);
    check("ovr_flag", {31'h0, overrun}, 32'h1);
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    check("ovr_cleared", {31'h0, overrun}, 32'h0);
    check("ovr_data_kept", {24'h0, data_out}, 32'h11);
    clr_ovr = 1'b1;
    send_word(8'h33);
    check("ovr_beats_clr", {31'h0, overrun}, 32'h1);
    check("ovr_data_kept2", {24'h0, data_out}, 32'h11);
    tick();
    clr_ovr = 1'b0;
    check("ovr_cleared2", {31'h0, overrun}, 32'h0);
    sb.push_back(8'h11);
    out_ready = 1'b1;
    tick();
    check("ovr_consumed", {31'h0, out_valid}, 32'h0);

    // sync alone restarts the count
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("sync_idle_busy", {31'h0, busy}, 32'h0);

    // 3 garbage bits, then sync on the first bit of 0x5A
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    check("garbage_busy", {31'h0, busy}, 32'h1);
    sb.push_back(8'h5A);
    for (int i = 0; i < 8; i++) begin
      send_bit(1'(8'h5A >> i), i == 0);
      if (i == 6) check("sync_no_early", {31'h0, out_valid}, 32'h0);
    end
    check("sync_valid", {31'h0, out_valid}, 32'h1);
    check("sync_data", {24'h0, data_out}, 32'h5A);
    tick();

    // async reset mid-word with a word pending
    out_ready = 1'b0;
    send_word(8'h42);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    check("pre_rst_valid", {31'h0, out_valid}, 32'h1);
    #2 rst = 1'b0;
    #1;
    check("arst_data", {24'h0, data_out}, 32'h0);
    check("arst_valid", {31'h0, out_valid}, 32'h0);
    check("arst_busy", {31'h0, busy}, 32'h0);
    check("arst_ovr", {31'h0, overrun}, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    send_word(8'hFF);
    check("post_rst_data", {24'h0, data_out}, 32'hFF);
    check("post_rst_valid", {31'h0, out_valid}, 32'h1);
    sb.push_back(8'hFF);
    out_ready = 1'b1;
    tick();

    // link with the PISO transmitter
    sb.push_back(8'h96);
    link_send(8'h96);
    check("link_96", {24'h0, data_out}, 32'h96);
    tick();
    sb.push_back(8'h00);
    link_send(8'h00);
    check("link_00_valid", {31'h0, out_valid}, 32'h1);
    check("link_00", {24'h0, data_out}, 32'h00);
    tick();
    sb.push_back(8'h80);
    link_send(8'h80);
    check("link_80", {24'h0, data_out}, 32'h80);
    tick();
    tick();

    check("sb_drained", sb.size(), 32'h0);
    check("final_ovr", {31'h0, overrun}, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
